// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch-stage reset constants and FSM encoding.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        BUF   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and instruction memory.
interface fetch_unit_if;

    logic                       imem_req;
    logic [cpu_pkg::XLEN-1:0]   imem_addr;
    logic                       imem_ack;
    logic [cpu_pkg::XLEN-1:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: taken branch over jump over sequential PC+4.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc_c,
    output logic            redirect_c
);

    always_comb begin
        next_pc_c  = pc_plus4;
        redirect_c = 1'b0;
        if (branch_taken) begin
            next_pc_c  = branch_target;
            redirect_c = 1'b1;
        end else if (jump) begin
            next_pc_c  = jump_target;
            redirect_c = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, sequences variable-latency imem requests,
// buffers a word across load-use stalls and drains stale requests after redirects.
module fetch_unit #(
    parameter logic [cpu_pkg::XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [cpu_pkg::XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        hazard_hold,
    input  logic                        jump,
    input  logic [cpu_pkg::XLEN-1:0]    jump_target,
    input  logic                        branch_taken,
    input  logic [cpu_pkg::XLEN-1:0]    branch_target,
    fetch_unit_if.master                bus,
    output logic [cpu_pkg::XLEN-1:0]    Inst,
    output logic [cpu_pkg::XLEN-1:0]    Pc4,
    output logic                        fetch_stall,
    output logic [cpu_pkg::XLEN-1:0]    pc
);

    import cpu_pkg::*;

    fetch_state_t       state, state_d;
    logic [XLEN-1:0]    pc_d;
    logic [XLEN-1:0]    buf_inst, buf_inst_d;
    logic [XLEN-1:0]    req_addr, req_addr_d;
    logic [XLEN-1:0]    pc_plus4;
    logic [XLEN-1:0]    next_pc;
    logic               redirect;

    assign pc_plus4 = pc + XLEN'(4);

    pc_next_sel u_pc_next_sel (
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .next_pc_c     (next_pc),
        .redirect_c    (redirect)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            buf_inst <= '0;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            buf_inst <= buf_inst_d;
            req_addr <= req_addr_d;
        end
    end

    // next_pc already folds in the redirect priority, so it doubles as PC+4 when none is active
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        buf_inst_d = buf_inst;
        req_addr_d = req_addr;
        unique case (state)
            FETCH: begin
                if (bus.imem_ack) begin
                    if (redirect) begin
                        pc_d = next_pc;
                    end else if (hazard_hold) begin
                        buf_inst_d = bus.imem_rdata;
                        state_d    = BUF;
                    end else begin
                        pc_d = next_pc;
                    end
                end else if (redirect) begin
                    req_addr_d = pc;
                    pc_d       = next_pc;
                    state_d    = DRAIN;
                end
            end
            BUF: begin
                if (redirect || !hazard_hold) begin
                    pc_d    = next_pc;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    pc_d = next_pc;
                end
                if (bus.imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // Outputs: bubble by default; a word is presented only when it is usable this cycle
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = pc;
        Inst          = NOP_INST;
        Pc4           = pc_plus4;
        fetch_stall   = 1'b1;
        if (!reset) begin
            unique case (state)
                FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ack && !redirect && !hazard_hold) begin
                        Inst        = bus.imem_rdata;
                        fetch_stall = 1'b0;
                    end
                end
                BUF: begin
                    Inst        = buf_inst;
                    fetch_stall = 1'b0;
                end
                DRAIN: begin
                    bus.imem_req  = 1'b1;
                    bus.imem_addr = req_addr;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable memory that returns each word's own address.
module tb_fetch_unit;

    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hazard_hold = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] Inst, Pc4, pc;
    logic        fetch_stall;

    int   n_checks = 0;
    int   n_fail = 0;
    int   lat = 0;
    logic force_ack = 1'b0;
    int   wait_cnt;

    always #5 clock = ~clock;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .hazard_hold   (hazard_hold),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .bus           (bus),
        .Inst          (Inst),
        .Pc4           (Pc4),
        .fetch_stall   (fetch_stall),
        .pc            (pc)
    );

    // Memory acks after `lat` waiting cycles (0 = same cycle) and returns the address as data
    always_ff @(posedge clock) begin
        if (reset || !bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                                        wait_cnt <= wait_cnt + 1;
    end
    assign bus.imem_ack   = force_ack || (bus.imem_req && (wait_cnt >= lat));
    assign bus.imem_rdata = bus.imem_addr;

    task automatic do_reset();
        reset = 1'b1; hazard_hold = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        force_ack = 1'b0; lat = 0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; force_ack = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req, Inst, fetch_stall} !== {1'b0, NOP_INST, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: req/inst/stall got %b/%h/%b want 0/%h/1", bus.imem_req, Inst, fetch_stall, NOP_INST);
        end
        @(negedge clock); #1;
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_pc: pc got %h want 00000000", pc);
        end
        force_ack = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if ({bus.imem_req, Inst, Pc4, fetch_stall} !== {1'b1, 32'(4*i), 32'(4*i+4), 1'b0}) begin
                n_fail++;
                $display("FAIL zero_wait[%0d]: req/inst/pc4/stall got %b/%h/%h/%b want 1/%h/%h/0",
                         i, bus.imem_req, Inst, Pc4, fetch_stall, 32'(4*i), 32'(4*i+4));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_two_cycle();
        do_reset();
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'(4*i), NOP_INST, 32'(4*i+4), 1'b1}) begin
                n_fail++;
                $display("FAIL two_cycle_bubble[%0d]: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/%h/%h/%h/1",
                         i, bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall, 32'(4*i), NOP_INST, 32'(4*i+4));
            end
            @(negedge clock); #1;
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'(4*i), 32'(4*i), 32'(4*i+4), 1'b0}) begin
                n_fail++;
                $display("FAIL two_cycle_word[%0d]: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/%h/%h/%h/0",
                         i, bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall, 32'(4*i), 32'(4*i), 32'(4*i+4));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_hazard_hold();
        do_reset();
        repeat (4) @(negedge clock);
        hazard_hold = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, Inst, fetch_stall} !== {1'b1, 32'h10, NOP_INST, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_ack: req/addr/inst/stall got %b/%h/%h/%b want 1/00000010/%h/1",
                     bus.imem_req, bus.imem_addr, Inst, fetch_stall, NOP_INST);
        end
        @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) hazard_hold = 1'b0;
            #1;
            n_checks++;
            if ({bus.imem_req, Inst, Pc4, fetch_stall} !== {1'b0, 32'h10, 32'h14, 1'b0}) begin
                n_fail++;
                $display("FAIL hold_buf[%0d]: req/inst/pc4/stall got %b/%h/%h/%b want 0/00000010/00000014/0",
                         k, bus.imem_req, Inst, Pc4, fetch_stall);
            end
            @(negedge clock);
        end
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'h14, 32'h14, 32'h18, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_release: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/00000014/00000014/00000018/0",
                     bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall);
        end
        @(negedge clock);
    endtask

    task automatic test_branch_drain();
        do_reset();
        repeat (8) @(negedge clock);
        lat = 3;
        branch_taken = 1'b1; branch_target = 32'h100;
        jump = 1'b1; jump_target = 32'h200;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, Inst, fetch_stall} !== {1'b1, 32'h20, NOP_INST, 1'b1}) begin
            n_fail++;
            $display("FAIL branch_issue: req/addr/inst/stall got %b/%h/%h/%b want 1/00000020/%h/1",
                     bus.imem_req, bus.imem_addr, Inst, fetch_stall, NOP_INST);
        end
        @(negedge clock);
        branch_taken = 1'b0; jump = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'h20, NOP_INST, 32'h104, 1'b1}) begin
                n_fail++;
                $display("FAIL drain[%0d]: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/00000020/%h/00000104/1",
                         k, bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall, NOP_INST);
            end
            @(negedge clock);
        end
        lat = 0;
        #1;
        n_checks++;
        if ({bus.imem_addr, Inst, Pc4, fetch_stall, pc} !== {32'h100, 32'h100, 32'h104, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL branch_target: addr/inst/pc4/stall/pc got %h/%h/%h/%b/%h want 00000100/00000100/00000104/0/00000100",
                     bus.imem_addr, Inst, Pc4, fetch_stall, pc);
        end
        @(negedge clock);
    endtask

    task automatic test_hold_vs_branch();
        do_reset();
        hazard_hold = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        #1;
        n_checks++;
        if ({bus.imem_req, Inst, Pc4, fetch_stall} !== {1'b1, NOP_INST, 32'h4, 1'b1}) begin
            n_fail++;
            $display("FAIL hold_branch_issue: req/inst/pc4/stall got %b/%h/%h/%b want 1/%h/00000004/1",
                     bus.imem_req, Inst, Pc4, fetch_stall, NOP_INST);
        end
        @(negedge clock);
        hazard_hold = 1'b0; branch_taken = 1'b0;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'h40, 32'h40, 32'h44, 1'b0}) begin
            n_fail++;
            $display("FAIL hold_branch_target: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/00000040/00000040/00000044/0",
                     bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall);
        end
        @(negedge clock);
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if ({Inst, fetch_stall} !== {NOP_INST, 1'b1}) begin
            n_fail++;
            $display("FAIL jump_issue: inst/stall got %h/%b want %h/1", Inst, fetch_stall, NOP_INST);
        end
        @(negedge clock);
        jump = 1'b0;
        #1;
        n_checks++;
        if ({bus.imem_addr, Inst, Pc4, fetch_stall} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_top: addr/inst/pc4/stall got %h/%h/%h/%b want fffffffc/fffffffc/00000000/0",
                     bus.imem_addr, Inst, Pc4, fetch_stall);
        end
        @(negedge clock); #1;
        n_checks++;
        if ({bus.imem_addr, Inst, Pc4, fetch_stall} !== {32'h0, 32'h0, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_zero: addr/inst/pc4/stall got %h/%h/%h/%b want 00000000/00000000/00000004/0",
                     bus.imem_addr, Inst, Pc4, fetch_stall);
        end
        @(negedge clock);
        lat = 3;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_ack, bus.imem_addr} !== {1'b1, 1'b0, 32'h4}) begin
            n_fail++;
            $display("FAIL pending: req/ack/addr got %b/%b/%h want 1/0/00000004", bus.imem_req, bus.imem_ack, bus.imem_addr);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.imem_req, fetch_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_req: req/stall got %b/%b want 0/1", bus.imem_req, fetch_stall);
        end
        @(negedge clock); #1;
        n_checks++;
        if (pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_pc: pc got %h want 00000000", pc);
        end
        reset = 1'b0; lat = 0;
        #1;
        n_checks++;
        if ({bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall} !== {1'b1, 32'h0, 32'h0, 32'h4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_refetch: req/addr/inst/pc4/stall got %b/%h/%h/%h/%b want 1/00000000/00000000/00000004/0",
                     bus.imem_req, bus.imem_addr, Inst, Pc4, fetch_stall);
        end
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_zero_wait();
        test_two_cycle();
        test_hazard_hold();
        test_branch_drain();
        test_hold_vs_branch();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
